// File: rtl/spi_master_pkg.sv
// Shared types and elaboration helpers for the spi_master_gen SPI writer.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Chip-select index width; a single slave still needs one bit.
  function automatic int cs_width(input int ncs);
    return (ncs <= 1) ? 1 : $clog2(ncs);
  endfunction

  function automatic bit params_ok(input int dw, input int dep, input int clk_div,
                                   input int ncs, input int cpol, input int cpha);
    return (dw >= 8) && (dw <= 32) &&
           (dep >= 2) && ((dep & (dep - 1)) == 0) &&
           (clk_div >= 2) && ((clk_div % 2) == 0) &&
           (ncs >= 1) &&
           ((cpol == 0) || (cpol == 1)) &&
           ((cpha == 0) || (cpha == 1));
  endfunction

endpackage

// File: rtl/spi_master_gen_if.sv
// Write-side handshake between the register writer and spi_master_gen.
interface spi_master_gen_if #(
  parameter int DW  = 24,
  parameter int NCS = 1
);
  import spi_master_pkg::*;

  localparam int CSW = cs_width(NCS);

  logic [DW-1:0]  wr_data;
  logic [CSW-1:0] wr_cs;
  logic           wr_en;
  logic           fifo_full;
  logic           fifo_empty;
  logic           overflow;

  modport master (
    output wr_data, wr_cs, wr_en,
    input  fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  wr_data, wr_cs, wr_en,
    output fifo_full, fifo_empty, overflow
  );

endinterface

// File: rtl/spi_tx_fifo.sv
// Show-ahead FIFO of {cs, data} entries; head is valid whenever empty is low.
module spi_tx_fifo #(
  parameter int W   = 25,
  parameter int DEP = 16
) (
  input  logic         clk,
  input  logic         RSTn,
  input  logic [W-1:0] push_data,
  input  logic         push_req,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = $clog2(DEP);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEP);

  logic [W-1:0]  mem [DEP];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          overflow_reg;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok  = push_req && !full_reg;
  assign pop_ok   = pop && !empty_reg;
  assign head     = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign overflow = overflow_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Storage is not cleared on reset; zeroing the pointers discards it.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      full_reg     <= (count_next == FULL_CNT);
      empty_reg    <= (count_next == '0);
      overflow_reg <= push_req && full_reg;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Queued multi-slave SPI writer, MSB first, configurable mode and divider.
// Define SPI_MISO_EN to add MISO capture (rx_data / rx_valid).
module spi_master_gen
  import spi_master_pkg::*;
#(
  parameter int DW      = 24,
  parameter int DEP     = 16,
  parameter int CLK_DIV = 6,
  parameter int NCS     = 1,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0
) (
  input  logic           clk,
  input  logic           RSTn,
  spi_master_gen_if.slave wr_if,
  output logic           busy,
  output logic           spi_clk,
  output logic           spi_mosi,
  output logic [NCS-1:0] spi_cs_n,
  input  logic           spi_miso
`ifdef SPI_MISO_EN
  ,
  output logic [DW-1:0]  rx_data,
  output logic           rx_valid
`endif
);

  localparam int CSW  = cs_width(NCS);
  localparam int HALF = CLK_DIV / 2;
  localparam int HCW  = $clog2(HALF) + 1;
  localparam int BCW  = $clog2(2 * DW) + 1;
  localparam logic           SCK_IDLE  = 1'(CPOL);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(2 * DW - 1);

  if (!params_ok(DW, DEP, CLK_DIV, NCS, CPOL, CPHA)) begin : g_param_check
    $error("spi_master_gen: illegal parameter set");
  end

  state_t           state_reg;
  logic [HCW-1:0]   hcnt_reg;
  logic [BCW-1:0]   bcnt_reg;
  logic [DW-2:0]    shreg_reg;
  logic [DW+CSW-1:0] head;
  logic [DW-1:0]    head_data;
  logic [CSW-1:0]   head_cs;
  logic [NCS-1:0]   cs_sel;
  logic             fifo_pop;
  logic             half_done;
  logic             shift_mosi;

  assign {head_cs, head_data} = head;
  assign fifo_pop  = (state_reg == IDLE) && !wr_if.fifo_empty;
  assign half_done = (hcnt_reg == HALF_LAST);

  // MOSI advances after trailing edges (CPHA=0) or on leading edges but the first (CPHA=1).
  assign shift_mosi = (CPHA == 0) ? (bcnt_reg[0] && (bcnt_reg != BIT_LAST))
                                  : (!bcnt_reg[0] && (bcnt_reg != '0));

  spi_tx_fifo #(
    .W   (DW + CSW),
    .DEP (DEP)
  ) u_fifo (
    .clk       (clk),
    .RSTn      (RSTn),
    .push_data ({wr_if.wr_cs, wr_if.wr_data}),
    .push_req  (wr_if.wr_en),
    .pop       (fifo_pop),
    .head      (head),
    .full      (wr_if.fifo_full),
    .empty     (wr_if.fifo_empty),
    .overflow  (wr_if.overflow)
  );

  // Out-of-range indices match no slave, so the word shifts out with every CS high.
  genvar gi;
  for (gi = 0; gi < NCS; gi++) begin : g_cs_dec
    assign cs_sel[gi] = (head_cs == CSW'(gi));
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_reg <= IDLE;
      hcnt_reg  <= '0;
      bcnt_reg  <= '0;
      shreg_reg <= '0;
      spi_clk   <= SCK_IDLE;
      spi_mosi  <= 1'b0;
      spi_cs_n  <= '1;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!wr_if.fifo_empty) begin
            state_reg <= LEAD;
            hcnt_reg  <= '0;
            shreg_reg <= head_data[DW-2:0];
            spi_mosi  <= head_data[DW-1];
            spi_cs_n  <= ~cs_sel;
            spi_clk   <= SCK_IDLE;
            busy      <= 1'b1;
          end
        end
        LEAD: begin
          if (half_done) begin
            state_reg <= SHIFT;
            hcnt_reg  <= '0;
            bcnt_reg  <= '0;
          end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (half_done) begin
            hcnt_reg <= '0;
            spi_clk  <= ~spi_clk;
            if (shift_mosi) begin
              spi_mosi  <= shreg_reg[DW-2];
              shreg_reg <= {shreg_reg[DW-3:0], 1'b0};
            end
            if (bcnt_reg == BIT_LAST) state_reg <= TRAIL;
            else                      bcnt_reg  <= bcnt_reg + 1'b1;
          end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end
        TRAIL: begin
          if (half_done) begin
            state_reg <= GAP;
            hcnt_reg  <= '0;
            spi_cs_n  <= '1;
          end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (half_done) begin
            state_reg <= IDLE;
            hcnt_reg  <= '0;
            busy      <= 1'b0;
          end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          spi_cs_n  <= '1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_MISO_EN
  logic [DW-1:0] rx_shreg_reg;
  logic [DW-1:0] rx_shift_next;
  logic          sample_edge;
  logic          rx_last;

  // The slave's sampling edge is leading for CPHA=0 (even half-periods), trailing for CPHA=1.
  assign rx_shift_next = {rx_shreg_reg[DW-2:0], spi_miso};
  assign sample_edge   = (state_reg == SHIFT) && half_done && (bcnt_reg[0] == 1'(CPHA));
  assign rx_last       = (state_reg == SHIFT) && half_done && (bcnt_reg == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      rx_shreg_reg <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= rx_last;
      if (sample_edge) rx_shreg_reg <= rx_shift_next;
      if (rx_last)     rx_data      <= (CPHA != 0) ? rx_shift_next : rx_shreg_reg;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
`endif

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised successor to the single-channel 24-bit FM-tuner SPI writer.
- Accepts {chip-select index, data word} entries into an internal FIFO and serialises them MSB-first on a shared SCK/MOSI.
- Generalised in word width, FIFO depth, SCK divider, SPI mode (CPOL/CPHA) and number of chip selects, with one decoded active-low CS per slave.
- Sits between the control logic (register writer) and the external RF/synth chips.

Parameters:
- DW, 24: data bits per transfer; range 8..32.
- DEP, 16: FIFO depth in entries; power of two, at least 2.
- CLK_DIV, 6: clk cycles per SCK period; even, at least 2. HALF = CLK_DIV/2.
- NCS, 1: number of chip selects. CSW = max(1, clog2(NCS)).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = slave samples on the leading edge; 1 = slave samples on the trailing edge.

Ports:
- clk  in  1  system clock, 50 MHz
- RSTn  in  1  synchronous reset, active-low
- wr_data  in  DW  word to transmit
- wr_cs  in  CSW  target slave index
- wr_en  in  1  push request
- fifo_full  out  1  FIFO full
- fifo_empty  out  1  FIFO empty
- overflow  out  1  one-cycle pulse when wr_en is asserted while full
- busy  out  1  high in any state other than IDLE
- spi_clk  out  1  SCK
- spi_mosi  out  1  serial data out
- spi_cs_n  out  NCS  active-low chip selects
- spi_miso  in  1  serial data in (used only with SPI_MISO_EN)

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset is synchronous and active-low on RSTn; every register clears on the clk edge where RSTn = 0.
  - Reset values: spi_clk = CPOL, spi_cs_n = all 1, spi_mosi = 0, busy = 0, overflow = 0, fifo_empty = 1, fifo_full = 0.
  - Reset mid-transfer aborts immediately; CS deasserts on the next edge and FIFO contents are discarded.
- FIFO:
  - Show-ahead: head entry is valid while !empty.
  - A push is accepted only when wr_en = 1 and full = 0. A push while full is dropped and overflow pulses.
  - Simultaneous push and pop when not full: both occur and the count is unchanged.
  - Pop happens only on the IDLE-to-LEAD transition.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP.
  - IDLE: if !fifo_empty, load shift register and cs latch from the head, pop, then go to LEAD. Otherwise stay.
  - LEAD: HALF cycles. CS[cs] low, SCK = CPOL, MOSI = data MSB.
  - SHIFT: 2·DW half-periods of HALF cycles each. SCK toggles at the end of each half-period, giving DW full pulses.
    - CPHA = 0: MOSI advances after each trailing edge.
    - CPHA = 1: MOSI advances on each leading edge.
  - TRAIL: HALF cycles. SCK = CPOL, CS still low.
  - GAP: HALF cycles with all CS high. Then go to IDLE, which can restart on the next cycle.
- Timing:
  - CS low for exactly CLK_DIV·(DW+1) cycles; defaults give 150 cycles.
  - First CS fall occurs 2 clk cycles after an accepted wr_en into an empty, idle block.
- wr_cs ≥ NCS: the transfer runs with no CS asserted. This is not an error.
- Counters: half-period counter width clog2(HALF)+1; bit counter width clog2(2·DW)+1. No wrap-around inside a word.

Optional Feature:
- Macro: SPI_MISO_EN.
- When defined:
  - Adds outputs rx_data[DW] and rx_valid.
  - spi_miso is sampled on the slave's sampling edge into a DW-bit register, MSB first.
  - On entry to TRAIL, rx_data updates and rx_valid pulses for 1 cycle.
  - Reset values: rx_data = 0, rx_valid = 0.
- When undefined: those ports are absent, spi_miso is unused, and there is no capture logic.

Decomposition:
- Package spi_master_pkg holds:
  - state enum (IDLE=0, LEAD=1, SHIFT=2, TRAIL=3, GAP=4, 3 bits)
  - cs-width function
  - parameter-legality checks
- Sub-module spi_tx_fifo: synchronous show-ahead FIFO, width DW+CSW, depth DEP, synchronous active-low reset.

Test Plan:
1. Defaults, push 0xA5C3F0 with cs 0 → spi_cs_n low 150 cycles, 24 SCK rising edges, MOSI reads back 0xA5C3F0, then idle.
2. Push 17 words into an empty, idle block on back-to-back cycles with DEP = 16 → 1 word popped immediately, 16 queued; 17th push accepted (room after the pop). An 18th push while full gives overflow = 1 for one cycle, word lost; 17 transfers complete.
3. NCS = 4, CLK_DIV = 4, push cs 2 then cs 3 → only spi_cs_n[2] then [3] low, ≥ 2 cycles all-high between them, SCK period 4 clk.
4. CPOL = 1, CPHA = 1, DW = 8, push 0x81 → SCK idles high, MOSI changes on falling edges, samples on rising edges give 1000_0001.
5. Assert RSTn = 0 mid-SHIFT → next edge CS all high, SCK = CPOL, FIFO empty, no further transfer.
6. SPI_MISO_EN, MISO looped to MOSI, push 0x3C5A96 → rx_valid pulses once with rx_data = 0x3C5A96.
